// File: rtl/expr_tokenizer.sv
`default_nettype none
// ============================================================================
//  Module      : expr_tokenizer
//  Description : ASCII-to-token front end for the Calculator. Accepts one
//                character per handshake, accumulates signed decimal numbers,
//                splits "number + operator" into two tokens, tracks the
//                parenthesis depth and raises a sticky error on bad input.
//  Revision    : 1.0 - initial release
// ============================================================================
module expr_tokenizer #(
   parameter int DEPTH_W = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  char_in,
   input  logic        char_valid,
   output logic        char_ready,
   output logic [2:0]  opcode,
   output logic [15:0] operand,
   output logic        tok_valid,
   output logic        error
);

   // Token codes understood by the Calculator
   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_MUL   = 3'b001;
   localparam logic [2:0] OP_OPEN  = 3'b010;
   localparam logic [2:0] OP_CLOSE = 3'b011;
   localparam logic [2:0] OP_PUSH  = 3'b100;
   localparam logic [2:0] OP_EQUAL = 3'b101;

   localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_NEG       = 3'd1,
      ST_NUM       = 3'd2,
      ST_OPND_DONE = 3'd3,
      ST_EMIT_OP   = 3'd4,
      ST_ERR       = 3'd5
   } state_t;

   state_t               state_q;
   logic [15:0]          acc_q;
   logic                 neg_q;
   logic [DEPTH_W-1:0]   depth_q;
   logic [2:0]           op_q;
   logic                 tok_valid_q;
   logic [2:0]           opcode_q;
   logic [15:0]          operand_q;
   logic                 error_q;

   logic                 accept;
   logic                 is_digit;
   logic                 is_space;
   logic                 is_minus;
   logic                 is_plus;
   logic                 is_star;
   logic                 is_open;
   logic                 is_close;
   logic                 is_equal;
   logic [3:0]           digit;
   logic [15:0]          acc_mac_d;
   logic [15:0]          push_val_d;
   logic                 depth_zero;
   logic                 depth_max;

   // The only stall is the bubble used to emit the operator of a split token
   assign char_ready = (state_q != ST_EMIT_OP);
   assign accept     = char_valid && char_ready;

   assign tok_valid  = tok_valid_q;
   assign opcode     = opcode_q;
   assign operand    = operand_q;
   assign error      = error_q;

   // Character classification plus the arithmetic shared by several states
   always_comb begin
      is_digit   = (char_in >= 8'h30) && (char_in <= 8'h39);
      is_space   = (char_in == 8'h20);
      is_minus   = (char_in == 8'h2D);
      is_plus    = (char_in == 8'h2B);
      is_star    = (char_in == 8'h2A);
      is_open    = (char_in == 8'h28);
      is_close   = (char_in == 8'h29);
      is_equal   = (char_in == 8'h3D);
      // ASCII '0'..'9' are 0x30..0x39, so the low nibble is the digit value
      digit      = char_in[3:0];
      // Wraps modulo 2^16 on purpose; overflow is not an error
      acc_mac_d  = (acc_q * 16'd10) + {12'd0, digit};
      push_val_d = neg_q ? (16'd0 - acc_q) : acc_q;
      depth_zero = (depth_q == '0);
      depth_max  = (depth_q == '1);
   end

   // Tokenizer FSM with registered token outputs and sticky error
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         acc_q       <= 16'd0;
         neg_q       <= 1'b0;
         depth_q     <= '0;
         op_q        <= OP_ADD;
         tok_valid_q <= 1'b0;
         opcode_q    <= OP_ADD;
         operand_q   <= 16'd0;
         error_q     <= 1'b0;
      end else begin
         tok_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  if (is_digit) begin
                     state_q <= ST_NUM;
                     acc_q   <= {12'd0, digit};
                     neg_q   <= 1'b0;
                  end else if (is_minus) begin
                     state_q <= ST_NEG;
                  end else if (is_open) begin
                     if (depth_max) begin
                        state_q <= ST_ERR;
                        error_q <= 1'b1;
                     end else begin
                        depth_q     <= depth_q + DEPTH_ONE;
                        tok_valid_q <= 1'b1;
                        opcode_q    <= OP_OPEN;
                        operand_q   <= 16'd0;
                     end
                  end else if (!is_space) begin
                     state_q <= ST_ERR;
                     error_q <= 1'b1;
                  end
               end
            end

            ST_NEG: begin
               if (accept) begin
                  if (is_digit) begin
                     state_q <= ST_NUM;
                     acc_q   <= {12'd0, digit};
                     neg_q   <= 1'b1;
                  end else if (!is_space) begin
                     state_q <= ST_ERR;
                     error_q <= 1'b1;
                  end
               end
            end

            ST_NUM: begin
               if (accept) begin
                  if (is_digit) begin
                     acc_q <= acc_mac_d;
                  end else if (is_space) begin
                     state_q     <= ST_OPND_DONE;
                     tok_valid_q <= 1'b1;
                     opcode_q    <= OP_PUSH;
                     operand_q   <= push_val_d;
                  end else if (is_plus || is_star ||
                               (is_close && !depth_zero) ||
                               (is_equal && depth_zero)) begin
                     // Push now, the latched operator follows next cycle
                     state_q     <= ST_EMIT_OP;
                     tok_valid_q <= 1'b1;
                     opcode_q    <= OP_PUSH;
                     operand_q   <= push_val_d;
                     if (is_plus) begin
                        op_q <= OP_ADD;
                     end else if (is_star) begin
                        op_q <= OP_MUL;
                     end else if (is_close) begin
                        op_q    <= OP_CLOSE;
                        depth_q <= depth_q - DEPTH_ONE;
                     end else begin
                        op_q    <= OP_EQUAL;
                        depth_q <= '0;
                     end
                  end else begin
                     state_q <= ST_ERR;
                     error_q <= 1'b1;
                  end
               end
            end

            ST_OPND_DONE: begin
               if (accept) begin
                  if (is_plus) begin
                     state_q     <= ST_IDLE;
                     tok_valid_q <= 1'b1;
                     opcode_q    <= OP_ADD;
                     operand_q   <= 16'd0;
                  end else if (is_star) begin
                     state_q     <= ST_IDLE;
                     tok_valid_q <= 1'b1;
                     opcode_q    <= OP_MUL;
                     operand_q   <= 16'd0;
                  end else if (is_close && !depth_zero) begin
                     depth_q     <= depth_q - DEPTH_ONE;
                     tok_valid_q <= 1'b1;
                     opcode_q    <= OP_CLOSE;
                     operand_q   <= 16'd0;
                  end else if (is_equal && depth_zero) begin
                     state_q     <= ST_IDLE;
                     tok_valid_q <= 1'b1;
                     opcode_q    <= OP_EQUAL;
                     operand_q   <= 16'd0;
                  end else if (!is_space) begin
                     state_q <= ST_ERR;
                     error_q <= 1'b1;
                  end
               end
            end

            ST_EMIT_OP: begin
               tok_valid_q <= 1'b1;
               opcode_q    <= op_q;
               operand_q   <= 16'd0;
               state_q     <= (op_q == OP_CLOSE) ? ST_OPND_DONE : ST_IDLE;
            end

            ST_ERR: begin
               // Drain and discard until reset
               error_q <= 1'b1;
            end

            default: begin
               state_q <= ST_ERR;
               error_q <= 1'b1;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_expr_tokenizer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_expr_tokenizer
//  Description : Directed self-checking bench for expr_tokenizer
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_expr_tokenizer;

   localparam logic [2:0] OP_ADD   = 3'b000;
   localparam logic [2:0] OP_MUL   = 3'b001;
   localparam logic [2:0] OP_OPEN  = 3'b010;
   localparam logic [2:0] OP_CLOSE = 3'b011;
   localparam logic [2:0] OP_PUSH  = 3'b100;
   localparam logic [2:0] OP_EQUAL = 3'b101;

   logic        clk;
   logic        rst;
   logic [7:0]  char_in;
   logic        char_valid;
   logic        char_ready;
   logic [2:0]  opcode;
   logic [15:0] operand;
   logic        tok_valid;
   logic        error;

   int          n_checks;
   int          n_pass;
   int          ready_lo_cnt;
   logic [18:0] tok_log[$];

   expr_tokenizer #(.DEPTH_W(4)) u_dut (
      .clk        (clk),
      .rst        (rst),
      .char_in    (char_in),
      .char_valid (char_valid),
      .char_ready (char_ready),
      .opcode     (opcode),
      .operand    (operand),
      .tok_valid  (tok_valid),
      .error      (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Token and stall observer, sampled away from the active edge
   initial ready_lo_cnt = 0;
   always @(negedge clk) begin
      if (!rst && tok_valid) tok_log.push_back({opcode, operand});
      if (!rst && !char_ready) ready_lo_cnt = ready_lo_cnt + 1;
   end

   function automatic logic [18:0] tk(input logic [2:0] op, input logic [15:0] val);
      return {op, val};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
   endtask

   // Called at a negedge; returns at the negedge after the accepting posedge
   task automatic send_char(input logic [7:0] c);
      int guard;
      guard      = 0;
      char_in    = c;
      char_valid = 1'b1;
      while (!char_ready && guard < 8) begin
         @(negedge clk);
         guard++;
      end
      if (guard >= 8) chk("send timeout", 32'd0, 32'd1);
      @(negedge clk);
   endtask

   task automatic send_str(input string s, input bit gaps);
      for (int i = 0; i < s.len(); i++) begin
         if (gaps && ($urandom_range(0, 2) == 0)) begin
            char_valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(negedge clk);
         end
         send_char(s[i]);
      end
      char_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      char_valid = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst        = 1'b1;
      char_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_tokens(input string tag, input int start, input logic [18:0] exp_q[$]);
      int n;
      n = tok_log.size() - start;
      chk({tag, " count"}, n, exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < n) chk($sformatf("%s tok%0d", tag, i), {13'd0, tok_log[start + i]}, {13'd0, exp_q[i]});
      end
   endtask

   task automatic check_err_end(input string tag, input int start, input logic [18:0] exp_q[$]);
      idle(3);
      check_tokens(tag, start, exp_q);
      chk({tag, " error"}, error, 1);
      chk({tag, " ready"}, char_ready, 1);
      // Further input is drained without tokens
      send_str("1+2=", 1'b0);
      idle(3);
      chk({tag, " drain count"}, tok_log.size() - start, exp_q.size());
      chk({tag, " drain error"}, error, 1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [18:0] e[$];
      int          s;
      int          r0;

      n_checks   = 0;
      n_pass     = 0;
      rst        = 1'b1;
      char_in    = 8'h00;
      char_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset tok_valid", tok_valid, 0);
      chk("reset opcode", opcode, 0);
      chk("reset operand", operand, 0);
      chk("reset error", error, 0);
      chk("reset ready", char_ready, 1);
      rst = 1'b0;
      @(negedge clk);

      // Back-to-back "2*3="
      s  = tok_log.size();
      r0 = ready_lo_cnt;
      send_str("2*3=", 1'b0);
      idle(3);
      e = '{tk(OP_PUSH, 16'h0002), tk(OP_MUL, 16'h0), tk(OP_PUSH, 16'h0003), tk(OP_EQUAL, 16'h0)};
      check_tokens("b2b", s, e);
      chk("b2b ready low cycles", ready_lo_cnt - r0, 2);
      chk("b2b error", error, 0);

      // Nested expression with a negative operand
      s = tok_log.size();
      send_str("(2*3+(10+4+3)*-20+(6+5))=", 1'b0);
      idle(3);
      e = '{tk(OP_OPEN, 0), tk(OP_PUSH, 2), tk(OP_MUL, 0), tk(OP_PUSH, 3), tk(OP_ADD, 0),
            tk(OP_OPEN, 0), tk(OP_PUSH, 10), tk(OP_ADD, 0), tk(OP_PUSH, 4), tk(OP_ADD, 0),
            tk(OP_PUSH, 3), tk(OP_CLOSE, 0), tk(OP_MUL, 0), tk(OP_PUSH, 16'hFFEC), tk(OP_ADD, 0),
            tk(OP_OPEN, 0), tk(OP_PUSH, 6), tk(OP_ADD, 0), tk(OP_PUSH, 5), tk(OP_CLOSE, 0),
            tk(OP_CLOSE, 0), tk(OP_EQUAL, 0)};
      check_tokens("nest", s, e);
      chk("nest error", error, 0);

      // Spaces and 16-bit wrap with random handshake gaps
      s = tok_log.size();
      send_str("12 + 65536 =", 1'b1);
      idle(3);
      e = '{tk(OP_PUSH, 16'h000C), tk(OP_ADD, 0), tk(OP_PUSH, 16'h0000), tk(OP_EQUAL, 0)};
      check_tokens("wrap", s, e);
      chk("wrap error", error, 0);

      // Error cases
      do_reset();
      s = tok_log.size();
      send_str("3)", 1'b0);
      chk("3) error timing", error, 1);
      e = '{};
      check_err_end("3)", s, e);

      do_reset();
      s = tok_log.size();
      send_str("(4=", 1'b0);
      e = '{tk(OP_OPEN, 0)};
      check_err_end("(4=", s, e);

      do_reset();
      s = tok_log.size();
      send_str("5-", 1'b0);
      e = '{};
      check_err_end("5-", s, e);

      do_reset();
      s = tok_log.size();
      send_str("--1", 1'b0);
      e = '{};
      check_err_end("--1", s, e);

      do_reset();
      s = tok_log.size();
      send_str("(((((((((((((((", 1'b0);
      idle(2);
      chk("depth15 error", error, 0);
      chk("depth15 count", tok_log.size() - s, 15);
      send_str("(", 1'b0);
      e = '{};
      for (int i = 0; i < 15; i++) e.push_back(tk(OP_OPEN, 0));
      check_err_end("depth16", s, e);

      // Reset in the middle of "(4", with a character presented under reset
      do_reset();
      s = tok_log.size();
      send_str("(4", 1'b0);
      rst        = 1'b1;
      char_in    = "7";
      char_valid = 1'b1;
      @(negedge clk);
      chk("midrst tok_valid", tok_valid, 0);
      chk("midrst opcode", opcode, 0);
      chk("midrst operand", operand, 0);
      chk("midrst error", error, 0);
      chk("midrst ready", char_ready, 1);
      rst        = 1'b0;
      char_valid = 1'b0;
      @(negedge clk);
      e = '{tk(OP_OPEN, 0)};
      check_tokens("midrst", s, e);
      s = tok_log.size();
      send_str("7=", 1'b0);
      idle(3);
      e = '{tk(OP_PUSH, 7), tk(OP_EQUAL, 0)};
      check_tokens("after rst", s, e);
      chk("after rst error", error, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/expr_tokenizer.md
# expr_tokenizer

ASCII-to-token front end for the Calculator. Accepts an expression one character at a time over a valid/ready handshake and emits the Calculator's token stream on `opcode`/`operand`, one token per clock, qualified by `tok_valid`. Work per character:
- accumulate decimal numbers, with unary minus;
- split "number followed by operator" into two tokens;
- track parenthesis depth;
- flag malformed input.

## Interface
- `DEPTH_W`, default 4: width of the parenthesis depth counter; maximum depth is 2^DEPTH_W-1.
- `clk`  in  1: single clock, all logic on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `char_in`  in  8: ASCII character.
- `char_valid`  in  1: `char_in` is valid.
- `char_ready`  out  1: the tokenizer can accept a character. A character is accepted when `char_valid && char_ready`.
- `opcode`  out  3: token code.
  - 000 add, 001 mul, 010 open paren, 011 close paren, 100 push operand, 101 equal.
- `operand`  out  16: two's-complement value for push tokens; 0 for every other token.
- `tok_valid`  out  1: one-cycle strobe; `opcode`/`operand` are valid.
- `error`  out  1: sticky malformed-input flag.

## Operation
- Character classes: digit '0'-'9', '-', '+', '*', '(', ')', '=', space, other.
- Spaces are accepted and produce no token. The exception is state NUM, where a space terminates the number.
- Accumulator: 16 bits, acc <= acc*10 + d, modulo 2^16, with no overflow error.
  - Pushed value is `neg ? -acc : acc`, modulo 2^16.
- Depth counter:
  - '(' increments it.
  - ')' decrements it.
  - '=' clears it to 0.
- Every error check is made at acceptance. A character that fails a check emits no token and moves the FSM to ERR.

FSM states, per accepted character:
- IDLE (expecting an operand):
  - digit -> NUM, acc=d, neg=0;
  - '-' -> NEG;
  - '(' -> emit 010, stay in IDLE; ERR if depth is at maximum;
  - any other non-space -> ERR.
- NEG:
  - digit -> NUM, acc=d, neg=1;
  - any other non-space -> ERR.
- NUM:
  - digit -> update acc;
  - space -> emit push, go to OPND_DONE;
  - '+', '*', ')', '=' -> emit push, latch the operator, go to EMIT_OP;
  - anything else, including '-' and '(' -> ERR.
- OPND_DONE (expecting an operator):
  - '+' -> emit 000, go to IDLE;
  - '*' -> emit 001, go to IDLE;
  - ')' -> emit 011, stay in OPND_DONE;
  - '=' -> emit 101, go to IDLE;
  - any other non-space -> ERR.
- EMIT_OP:
  - `char_ready`=0; no character is accepted.
  - Emits the latched operator token.
  - Next state: OPND_DONE if the operator is ')', otherwise IDLE.
- ERR:
  - `error`=1, `char_ready`=1, so characters are drained and discarded.
  - No tokens. Leaves only on `rst`.

Conditions that send ')' or '=' to ERR, in NUM or OPND_DONE:
- ')' when depth is 0.
- '=' when depth is not 0.

## Timing
- Reset values:
  - state IDLE;
  - `tok_valid`=0, `opcode`=000, `operand`=0, `error`=0;
  - `char_ready`=1;
  - depth=0, acc=0, neg=0.
- `rst` overrides everything, including a character presented in the same cycle.
  - Reset mid-number discards the partial number; no token is emitted.
- Token outputs are registered. A token caused by the character accepted in cycle N has `tok_valid`=1 in cycle N+1.
  - `opcode`/`operand` hold their value when `tok_valid`=0.
- Two-token split, for a number terminated by an operator accepted in cycle N:
  - cycle N+1: push token, state EMIT_OP, `char_ready`=0;
  - cycle N+2: operator token, `char_ready`=1 again.
- `char_ready` is a combinational function of state and is low only in EMIT_OP. A held `char_valid` simply waits.
- Throughput: one character per clock, except a one-cycle bubble after each number-terminating operator. The result is at most one token per clock, which suits the Calculator.
- `error` rises in the cycle after the offending character is accepted.
  - `tok_valid` is 0 from that cycle on.
  - Tokens already emitted are not retracted.
- After '=', the tokenizer is in IDLE with depth 0, ready for the next expression without a reset.

## Test plan
- "2*3=" streamed back-to-back.
  - Required tokens: push 0x0002, mul, push 0x0003, equal.
  - `char_ready` is low for exactly 2 cycles: the cycle after the '*' is accepted and the cycle after the '=' is accepted.
- "(2*3+(10+4+3)*-20+(6+5))=".
  - Required tokens in order: open, push 2, mul, push 3, add, open, push 10, add, push 4, add, push 3, close, mul, push 0xFFEC, add, open, push 6, add, push 5, close, close, equal.
  - `error`=0 throughout.
- Spaces and wrap-around with "12 + 65536 =".
  - Required tokens: push 0x000C, add, push 0x0000, equal.
  - Hold `char_valid` high with random gaps; no character may be lost or duplicated.
- Errors, each with `rst` between cases. Each case must end with `error`=1, no further tokens, and `char_ready`=1.
  - "3)": push 3 is never emitted.
  - "(4=": push 4 is not emitted.
  - "5-".
  - "--1".
  - 16 consecutive '(' with the default `DEPTH_W`: the 16th sets `error`.
- Reset mid-operation.
  - Assert `rst` after "4" of "(4": no push is emitted.
  - Following "7=" must produce push 7, equal.
  - All outputs must be at their reset values in the cycle after `rst`.
